mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Parametrised successor to the CPU's byte-serial memory front end. It arbitrates the instruction-fetch line-fill port and the LSB data port onto the single 8-bit RAM/UART bus.
- Adds a configurable fetch-line length, signed/unsigned load extension, an explicit request-accept handshake, UART back-pressure on IO writes, and defined abort/stall semantics.
- Sits between the instruction unit / icache, the LSB, and the external mem_* pins.

Parameters:
LINE_BYTES, 16, instruction line-fill length in bytes; power of two, 4..64.
TAG_W, 4, width of the LSB entry tag echoed with a completion.
IO_SEL, 2'b11, value of address bits [17:16] that marks the IO-mapped region.

Ports:
clk_in  in  1  system clock.
rst_n_in  in  1  asynchronous active-low reset.
rdy_in  in  1  global ready; low freezes the block.
mem_din  in  8  RAM read byte, valid one cycle after its address.
mem_dout  out  8  write byte.
mem_a  out  32  byte address.
mem_wr  out  1  1 = write.
io_buffer_full  in  1  UART buffer full.
clear  in  1  pipeline flush.
if_req  in  1  line fill requested.
if_addr  in  32  fetch address; low log2(LINE_BYTES) bits are ignored.
if_done  out  1  one-cycle pulse: line valid.
if_line  out  LINE_BYTES*8  filled line, byte 0 in [7:0].
d_req  in  1  data request.
d_tag  in  TAG_W  LSB entry tag.
d_we  in  1  1 = store.
d_size  in  2  0 byte, 1 half, 2 word; 3 is treated as word.
d_signed  in  1  sign-extend the load result.
d_addr  in  32  byte address; misalignment is permitted.
d_wdata  in  32  store data, little-endian.
d_ack  out  1  request accepted this cycle (combinational).
d_done  out  1  one-cycle completion pulse.
d_rdata  out  32  extended load data.
d_tag_out  out  TAG_W  tag of the completing access.
busy  out  1  transaction in progress.

Behaviour:
- Reset (asynchronous, rst_n_in = 0): state IDLE; mem_wr, mem_a, mem_dout, if_done, d_done, d_rdata, d_tag_out, if_line and busy all 0.
- States: IDLE, IRD, DRD, DWR, IOWAIT.
- rdy_in low:
  - All registers hold and mem_wr is forced to 0.
  - A read byte is captured only if rdy_in was high both in the address cycle and in the capture cycle; otherwise that address is re-issued.
- IDLE acceptance:
  - Nothing is accepted when clear = 1.
  - Priority is d_req over if_req.
  - On accept, mem_a, mem_wr and mem_dout are driven combinationally from the winning request, so byte 0 issues in the accept cycle t.
  - d_ack is high in cycle t for data accepts only.
  - busy goes high from t+1.
- Byte count and addressing:
  - Access length N = 1 << d_size for data, LINE_BYTES for fetch.
  - Byte k goes to address base + k, computed mod 2^32.
- Load (DRD) / fill (IRD):
  - Bytes are issued in cycles t..t+N-1 and captured in t+1..t+N.
  - d_done / if_done pulse in cycle t+N+1 (registered).
  - d_rdata bits above 8N are zero- or sign-extended per d_signed.
  - if_line holds its value until the next fill completes.
- Store (DWR):
  - Byte k = d_wdata[8k+7:8k] with mem_wr = 1, in cycles t..t+N-1.
  - d_done pulses at t+N.
- IO region (d_addr[17:16] == IO_SEL):
  - Loads and stores behave as above, with the address held constant for all bytes (no increment).
  - A store while io_buffer_full = 1 enters IOWAIT: mem_wr = 0, no byte consumed.
  - The store resumes the cycle after io_buffer_full falls.
  - io_buffer_full is checked before each byte.
- clear while busy:
  - IRD and DRD abort within one cycle: return to IDLE, no done pulse, captured bytes discarded.
  - DWR and IOWAIT are committed stores and ignore clear.
- if_addr line changes while in IRD: the fill is aborted the same way as clear.
- Simultaneous d_done and a new request: the new request is accepted only from IDLE, one cycle after done; back-to-back accesses have no further gap.

Decomposition:
- Package mem_ctrl_pkg: state encoding, size constants (SZ_B/SZ_H/SZ_W), io_region(addr) function, length(size) function.
- One sub-module, mem_load_ext: 32-bit byte assembler plus zero/sign extension, keyed by size and signed.

Test Plan:
- Word load: RAM[0x100..0x103] = 78 56 34 12, d_size = 2, d_signed = 0, accept at t -> mem_a = 0x100..0x103 in t..t+3; d_done at t+5; d_rdata = 0x12345678; d_tag_out = tag.
- Signed byte load at an address holding 0x80 -> d_rdata = 0xFFFFFF80; with d_signed = 0 -> 0x00000080.
- Store half 0xBEEF to 0x201 (misaligned) -> writes EF@0x201, BE@0x202; d_done at t+2.
- IO store byte 0x41 to 0x30000 with io_buffer_full high for 5 cycles -> mem_wr stays 0 for those 5 cycles; exactly one write of 0x41 after io_buffer_full falls.
- Line fill, LINE_BYTES = 16, if_addr = 0x1234 -> reads 0x1230..0x123F; if_done at t+17.
- Same fill with clear at t+6 -> no if_done; IDLE next cycle.
- Simultaneous d_req and if_req -> data served first (d_ack = 1), fill accepted immediately after d_done.
- rdy_in low for 3 cycles mid-load -> no duplicate writes; result identical to the unstalled run.
- Reset asserted mid-store -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared types: FSM states, access sizes and address/length helpers.
// Imported by the memory front end and its load extender.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IRD,
    S_DRD,
    S_DWR,
    S_IOWAIT
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic io_region(
    input logic [31:0] addr,
    input logic [1:0]  sel
  );
    return 2'(addr >> 16) == sel;
  endfunction

  function automatic logic [2:0] length(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load assembler: merges the incoming byte into the partial word,
// then zero/sign extends it to 32 bits by access size.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  idx_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  output logic [31:0] data_o
);

  logic [31:0] w;

  always_comb begin
    w = raw_i;
    w[{idx_i, 3'b000} +: 8] = byte_i;
    unique case (1'b1)
      (size_i == SZ_B): data_o = {{24{sgn_i & w[7]}}, w[7:0]};
      (size_i == SZ_H): data_o = {{16{sgn_i & w[15]}}, w[15:0]};
      default:          data_o = w;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory front end: arbitrates icache line fills and LSB
// accesses onto the 8-bit RAM/UART bus.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         LINE_BYTES = 16,
  parameter int         TAG_W      = 4,
  parameter logic [1:0] IO_SEL     = 2'b11
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    clear,
  input  logic                    if_req,
  input  logic [31:0]             if_addr,
  output logic                    if_done,
  output logic [LINE_BYTES*8-1:0] if_line,
  input  logic                    d_req,
  input  logic [TAG_W-1:0]        d_tag,
  input  logic                    d_we,
  input  logic [1:0]              d_size,
  input  logic                    d_signed,
  input  logic [31:0]             d_addr,
  input  logic [31:0]             d_wdata,
  output logic                    d_ack,
  output logic                    d_done,
  output logic [31:0]             d_rdata,
  output logic [TAG_W-1:0]        d_tag_out,
  output logic                    busy
);

  localparam int LB = $clog2(LINE_BYTES);
  localparam int CW = LB + 1;
  localparam int LW = LINE_BYTES * 8;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [31:0] LMASK = ~32'(LINE_BYTES - 1);

  state_e state_q, state_d;
  logic [31:0] base_q, base_d, wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [TAG_W-1:0] tag_q, tag_d, tag_out_q, tag_out_d;
  logic [1:0] size_q, size_d;
  logic sgn_q, sgn_d, io_q, io_d;
  logic [CW-1:0] len_q, len_d, iss_q, iss_d, cap_q, cap_d;
  logic [LW-1:0] line_q, line_d, if_line_q, if_line_d;
  logic d_done_q, d_done_d, if_done_q, if_done_d;
  logic rdy_q;

  logic accept_ok, cap_v, line_moved, wr_c;
  logic [CW-1:0] eidx;
  logic [31:0] rd_addr, wr_addr, ext_data;

  // A lost capture (stall in the data cycle) rewinds issue to the
  // first byte not yet captured.
  assign eidx = rdy_q ? iss_q : cap_q;
  assign cap_v = rdy_in && rdy_q && (iss_q > cap_q);
  assign rd_addr = io_q ? base_q : base_q + 32'(eidx);
  assign wr_addr = io_q ? base_q : base_q + 32'(iss_q);
  assign line_moved = ((if_addr ^ base_q) & LMASK) != 32'd0;
  assign accept_ok = rst_n_in && rdy_in && !clear
                     && !d_done_q && !if_done_q;

  mem_load_ext u_ext (
    .raw_i  (line_q[31:0]),
    .byte_i (mem_din),
    .idx_i  (cap_q[1:0]),
    .size_i (size_q),
    .sgn_i  (sgn_q),
    .data_o (ext_data)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    tag_d     = tag_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    io_d      = io_q;
    len_d     = len_q;
    iss_d     = iss_q;
    cap_d     = cap_q;
    line_d    = line_q;
    if_line_d = if_line_q;
    rdata_d   = rdata_q;
    tag_out_d = tag_out_q;
    d_done_d  = 1'b0;
    if_done_d = 1'b0;
    mem_a     = 32'd0;
    mem_dout  = 8'd0;
    wr_c      = 1'b0;
    d_ack     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_ok && d_req) begin
          d_ack   = 1'b1;
          base_d  = d_addr;
          wdata_d = d_wdata;
          tag_d   = d_tag;
          size_d  = d_size;
          sgn_d   = d_signed;
          io_d    = io_region(d_addr, IO_SEL);
          len_d   = CW'(length(d_size));
          cap_d   = '0;
          mem_a   = d_addr;
          if (!d_we) begin
            state_d = S_DRD;
            iss_d   = ONE;
          end else if (io_d && io_buffer_full) begin
            state_d = S_IOWAIT;
            iss_d   = '0;
          end else begin
            wr_c     = 1'b1;
            mem_dout = d_wdata[7:0];
            iss_d    = ONE;
            if (len_d == ONE) begin
              d_done_d  = 1'b1;
              tag_out_d = d_tag;
            end else begin
              state_d = S_DWR;
            end
          end
        end else if (accept_ok && if_req) begin
          base_d  = if_addr & LMASK;
          io_d    = 1'b0;
          len_d   = CW'(LINE_BYTES);
          iss_d   = ONE;
          cap_d   = '0;
          mem_a   = base_d;
          state_d = S_IRD;
        end
      end
      S_IRD, S_DRD: begin
        if (clear || (state_q == S_IRD && line_moved)) begin
          state_d = S_IDLE;
        end else begin
          iss_d = eidx;
          if (eidx < len_q) begin
            mem_a = rd_addr;
            iss_d = eidx + ONE;
          end
          if (cap_v) begin
            line_d[{cap_q[LB-1:0], 3'b000} +: 8] = mem_din;
            cap_d = cap_q + ONE;
            if (cap_d == len_q) begin
              state_d = S_IDLE;
              if (state_q == S_IRD) begin
                if_done_d = 1'b1;
                if_line_d = line_d;
              end else begin
                d_done_d  = 1'b1;
                rdata_d   = ext_data;
                tag_out_d = tag_q;
              end
            end
          end
        end
      end
      S_DWR: begin
        if (io_q && io_buffer_full) begin
          state_d = S_IOWAIT;
        end else begin
          mem_a    = wr_addr;
          wr_c     = 1'b1;
          mem_dout = wdata_q[{iss_q[1:0], 3'b000} +: 8];
          iss_d    = iss_q + ONE;
          if (iss_d == len_q) begin
            state_d   = S_IDLE;
            d_done_d  = 1'b1;
            tag_out_d = tag_q;
          end
        end
      end
      S_IOWAIT: begin
        mem_a = base_q;
        if (!io_buffer_full) state_d = S_DWR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      io_q      <= 1'b0;
      len_q     <= '0;
      iss_q     <= '0;
      cap_q     <= '0;
      line_q    <= '0;
      if_line_q <= '0;
      rdata_q   <= '0;
      tag_out_q <= '0;
      d_done_q  <= 1'b0;
      if_done_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= rdy_in;
      if (rdy_in) begin
        state_q   <= state_d;
        base_q    <= base_d;
        wdata_q   <= wdata_d;
        tag_q     <= tag_d;
        size_q    <= size_d;
        sgn_q     <= sgn_d;
        io_q      <= io_d;
        len_q     <= len_d;
        iss_q     <= iss_d;
        cap_q     <= cap_d;
        line_q    <= line_d;
        if_line_q <= if_line_d;
        rdata_q   <= rdata_d;
        tag_out_q <= tag_out_d;
        d_done_q  <= d_done_d;
        if_done_q <= if_done_d;
      end
    end
  end

  assign mem_wr    = wr_c & rdy_in;
  assign if_done   = if_done_q;
  assign if_line   = if_line_q;
  assign d_done    = d_done_q;
  assign d_rdata   = rdata_q;
  assign d_tag_out = tag_out_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed and random accesses
// against a byte-array RAM and an arithmetic load/store model.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n, rdy_in, io_full, clear, if_req;
  logic d_req, d_we, d_signed, mem_wr, if_done, d_ack, d_done, busy;
  logic [7:0] mem_din, mem_dout;
  logic [31:0] mem_a, if_addr, d_addr, d_wdata, d_rdata;
  logic [1:0] d_size;
  logic [3:0] d_tag, d_tag_out;
  logic [127:0] if_line;
  logic [7:0] ram [0:65535];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_full), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_line(if_line), .d_req(d_req), .d_tag(d_tag), .d_we(d_we),
    .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_done(d_done),
    .d_rdata(d_rdata), .d_tag_out(d_tag_out), .busy(busy)
  );

  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [3:0] tag,
                         input int stall_at, output logic [31:0] got);
    int n, done_c;
    logic io;
    longint v;
    logic [31:0] exp, a;
    logic [3:0] tg;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    io = (addr[17:16] == 2'b11);
    got = 32'hDEADBEEF;
    tg = 4'h0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_size = size;
    d_signed = sgn; d_tag = tag;
    v = 0;
    for (int k = 0; k < n; k++) begin
      a = io ? addr : addr + 32'(k);
      v += longint'(ram[a[15:0]]) << (8 * k);
    end
    if (sgn && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    exp = v[31:0];
    #3;
    chk("ld_ack", 32'(d_ack), 32'd1);
    chk("ld_addr0", mem_a, addr);
    done_c = -1;
    for (int c = 1; c < 60 && done_c < 0; c++) begin
      @(negedge clk);
      d_req = 1'b0;
      d_addr = $urandom;
      rdy_in = !(stall_at > 0 && c >= stall_at && c < stall_at + 3);
      #3;
      if (c == 1) chk("ld_busy", 32'(busy), 32'd1);
      if (stall_at < 0 && c < n)
        chk("ld_addr", mem_a, io ? addr : addr + 32'(c));
      if (d_done) begin
        done_c = c;
        got = d_rdata;
        tg = d_tag_out;
      end
    end
    chk("ld_done_seen", 32'(done_c >= 0), 32'd1);
    if (stall_at < 0) chk("ld_done_cyc", 32'(done_c), 32'(n + 1));
    chk("ld_data", got, exp);
    chk("ld_tag", 32'(tg), 32'(tag));
    @(negedge clk);
    rdy_in = 1'b1;
    #3;
    chk("ld_pulse", 32'(d_done), 32'd0);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] data, input logic [3:0] tag,
                          input int full_cycles);
    int n, w, done_c;
    logic io;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    io = (addr[17:16] == 2'b11);
    w = 0;
    done_c = -1;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_size = size;
    d_wdata = data; d_tag = tag; io_full = (full_cycles > 0);
    #3;
    chk("st_ack", 32'(d_ack), 32'd1);
    for (int c = 0; c < 60 && done_c < 0; c++) begin
      if (c > 0) begin
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0; d_wdata = $urandom;
        io_full = (c < full_cycles);
        #3;
      end
      if (c < full_cycles) chk("st_hold", 32'(mem_wr), 32'd0);
      if (mem_wr) begin
        if (w < n) begin
          chk("st_addr", mem_a, io ? addr : addr + 32'(w));
          chk("st_byte", 32'(mem_dout), 32'(data[8*w +: 8]));
        end
        w++;
      end
      if (d_done) begin
        done_c = c;
        chk("st_tag", 32'(d_tag_out), 32'(tag));
      end
    end
    io_full = 1'b0;
    chk("st_nbytes", 32'(w), 32'(n));
    if (full_cycles == 0) chk("st_done_cyc", 32'(done_c), 32'(n));
    else chk("st_done_seen", 32'(done_c > full_cycles), 32'd1);
  endtask

  // kind 0: clear pulse at abort_at; kind 1: if_addr moves to another line
  task automatic do_fill(input logic [31:0] addr, input int abort_at,
                         input int kind);
    int done_c;
    logic [31:0] base;
    logic [127:0] expl, got;
    base = {addr[31:4], 4'h0};
    got = '0;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    for (int i = 0; i < 16; i++) expl[8*i +: 8] = ram[16'(base + 32'(i))];
    #3;
    chk("fill_addr0", mem_a, base);
    done_c = -1;
    for (int c = 1; c < 40 && done_c < 0; c++) begin
      @(negedge clk);
      if_req = 1'b0;
      clear = (kind == 0 && c == abort_at);
      if (kind == 1 && c == abort_at) if_addr = addr + 32'h100;
      #3;
      if (abort_at < 0 && c < 16) chk("fill_addr", mem_a, base + 32'(c));
      if (abort_at > 0 && c == abort_at + 1) chk("fill_abort_idle", 32'(busy), 32'd0);
      if (if_done) begin
        done_c = c;
        got = if_line;
      end
    end
    clear = 1'b0;
    if (abort_at > 0) begin
      chk("fill_no_done", 32'(done_c < 0), 32'd1);
    end else begin
      chk("fill_done_cyc", 32'(done_c), 32'd17);
      for (int i = 0; i < 4; i++) chk("fill_line", got[32*i +: 32], expl[32*i +: 32]);
    end
  endtask

  initial begin
    logic [31:0] got, got2, exp;
    int dc, fc, ic;
    rst_n = 1'b0; rdy_in = 1'b1; io_full = 1'b0; clear = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_signed = 1'b0; d_size = '0; d_tag = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 65536; i++) ram[i] <= 8'($urandom);
    repeat (2) @(negedge clk);
    #3;
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_done", 32'({if_done, d_done, d_tag_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ram[16'h100] <= 8'h78; ram[16'h101] <= 8'h56;
    ram[16'h102] <= 8'h34; ram[16'h103] <= 8'h12;
    ram[16'h180] <= 8'h80;

    do_load(32'h100, 2'd2, 1'b0, 4'hA, -1, got);
    chk("word_load", got, 32'h12345678);
    do_load(32'h180, 2'd0, 1'b1, 4'h3, -1, got);
    chk("sbyte_load", got, 32'hFFFFFF80);
    do_load(32'h180, 2'd0, 1'b0, 4'h4, -1, got);
    chk("ubyte_load", got, 32'h00000080);
    repeat (16)
      do_load(32'($urandom_range(0, 32'hFFF0)), 2'($urandom),
              1'($urandom), 4'($urandom), -1, got);
    do_load(32'h30005, 2'd2, 1'b0, 4'h6, -1, got);

    do_store(32'h201, 2'd1, 32'h0000BEEF, 4'h7, 0);
    chk("st_ram_lo", 32'(ram[16'h201]), 32'hEF);
    chk("st_ram_hi", 32'(ram[16'h202]), 32'hBE);
    repeat (8)
      do_store(32'($urandom_range(0, 32'hFFF0)), 2'($urandom),
               $urandom, 4'($urandom), 0);
    do_store(32'h30000, 2'd0, 32'h00000041, 4'h9, 5);

    do_fill(32'h1234, -1, 0);
    do_fill(32'h1234, 6, 0);
    do_fill(32'h2468, 4, 1);
    do_fill(32'h3000, -1, 0);

    // concurrent data and fetch requests: data first, fill right after done
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_size = 2'd2;
    d_signed = 1'b0; d_tag = 4'h5; if_req = 1'b1; if_addr = 32'h800;
    exp = {ram[16'h403], ram[16'h402], ram[16'h401], ram[16'h400]};
    #3;
    chk("arb_ack", 32'(d_ack), 32'd1);
    chk("arb_addr", mem_a, 32'h400);
    dc = -1; fc = -1; ic = -1;
    for (int c = 1; c < 40 && ic < 0; c++) begin
      @(negedge clk);
      d_req = 1'b0;
      if (fc >= 0) if_req = 1'b0;
      #3;
      if (d_done) begin dc = c; got = d_rdata; end
      if (mem_a == 32'h800 && fc < 0) fc = c;
      if (if_done) ic = c;
    end
    if_req = 1'b0;
    chk("arb_d_done", 32'(dc), 32'd5);
    chk("arb_d_data", got, exp);
    chk("arb_fill_start", 32'(fc), 32'd6);
    chk("arb_if_done", 32'(ic), 32'd23);

    do_load(32'h500, 2'd2, 1'b1, 4'h2, -1, got);
    do_load(32'h500, 2'd2, 1'b1, 4'h2, 2, got2);
    do_load(32'h6F1, 2'd1, 1'b1, 4'h8, 1, got2);

    // reset in the middle of a store
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_size = 2'd2;
    d_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_mem_wr", 32'(mem_wr), 32'd0);
    chk("mrst_mem_a", mem_a, 32'd0);
    chk("mrst_mem_dout", 32'(mem_dout), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_rdata", d_rdata, 32'd0);
    chk("mrst_misc", 32'({d_ack, if_done, d_done, d_tag_out}), 32'd0);
    for (int i = 0; i < 4; i++) chk("mrst_line", if_line[32*i +: 32], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(32'h100, 2'd2, 1'b0, 4'h1, -1, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
